// File: rtl/wb_bus_arbiter.sv
// Purpose: shares one pipelined Wishbone master bus between the data port (p0) and the fetch port (p1), one owner per cyc tenure, round-robin on ties.
// Latency: grant one cycle after cyc is seen in IDLE; responses (ack/err/idata) pass through combinationally with zero added latency.
// Backpressure: owner stalls on wb_stall or when MAX_OUTSTANDING strobes are unacknowledged; non-owners are held stalled.
//
// Ports:
//   i_clk, i_reset_n            clock, asynchronous active-low reset
//   p0_* / p1_*                 requester side: cyc/stb/we/addr/sel/odata in, ack/err/stall/idata out
//   wb_*                        shared master side: cyc/stb/we/addr/sel/odata out, ack/stall/err/idata in

module wb_bus_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,

  input  logic        p0_cyc,
  input  logic        p0_stb,
  input  logic        p0_we,
  input  logic [29:0] p0_addr,
  input  logic [3:0]  p0_sel,
  input  logic [31:0] p0_odata,
  output logic        p0_ack,
  output logic        p0_err,
  output logic        p0_stall,
  output logic [31:0] p0_idata,

  input  logic        p1_cyc,
  input  logic        p1_stb,
  input  logic        p1_we,
  input  logic [29:0] p1_addr,
  input  logic [3:0]  p1_sel,
  input  logic [31:0] p1_odata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic        p1_stall,
  output logic [31:0] p1_idata,

  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [29:0] wb_addr,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_odata,
  input  logic        wb_ack,
  input  logic        wb_stall,
  input  logic        wb_err,
  input  logic [31:0] wb_idata
);

  localparam logic [3:0]  MAX_OUT   = 4'(MAX_OUTSTANDING);
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    ABORT = 2'd3
  } state_t;

  state_t      state;
  logic        last_grant;   // port that most recently entered a tenure
  logic [3:0]  outstanding;  // accepted strobes not yet answered
  logic [15:0] wdog;         // consecutive cycles waiting on a response
  logic        abort_owner;  // port whose tenure was killed by the watchdog

  logic        own0;
  logic        own1;
  logic        owning;
  logic        own_cyc;
  logic        own_stb;
  logic        abort_cyc;
  logic        room;
  logic        resp;
  logic        accept;
  logic        counting;
  logic        timeout;
  logic [3:0]  out_next;

  assign own0   = (state == OWN0);
  assign own1   = (state == OWN1);
  assign owning = own0 | own1;

  // Port 0 is the default mux source, so IDLE and ABORT present port 0's
  // address/data with strobe held low.
  assign own_cyc   = own1 ? p1_cyc : p0_cyc;
  assign own_stb   = own1 ? p1_stb : p0_stb;
  assign abort_cyc = abort_owner ? p1_cyc : p0_cyc;

  assign room = (outstanding < MAX_OUT);

  // ---------------------------------------------------------------------------
  // Master bus
  // ---------------------------------------------------------------------------
  // Strobe is also gated by cyc so a requester never strobes outside a tenure.
  assign wb_cyc   = owning & own_cyc;
  assign wb_stb   = owning & own_cyc & own_stb & room;
  assign wb_we    = own1 ? p1_we    : p0_we;
  assign wb_addr  = own1 ? p1_addr  : p0_addr;
  assign wb_sel   = own1 ? p1_sel   : p0_sel;
  assign wb_odata = own1 ? p1_odata : p0_odata;

  // ---------------------------------------------------------------------------
  // Outstanding tracking and watchdog
  // ---------------------------------------------------------------------------
  assign resp   = wb_ack | wb_err;
  assign accept = wb_stb & ~wb_stall;

  // The watchdog only runs while something is in flight and nothing answers.
  assign counting = owning & (outstanding != 4'd0) & ~resp;
  assign timeout  = counting & (wdog == WDOG_LAST);

  // An accept and a response in the same cycle cancel; a response with
  // nothing in flight is still forwarded but must not underflow the count.
  always_comb begin
    out_next = outstanding;
    if (accept && !resp) begin
      out_next = outstanding + 4'd1;
    end else if (!accept && resp && (outstanding != 4'd0)) begin
      out_next = outstanding - 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Requester responses
  // ---------------------------------------------------------------------------
  // The synthesized timeout error goes to the owner even when the slave
  // reports nothing, so the requester can unwind its own pipeline.
  assign p0_ack   = own0 & wb_ack;
  assign p0_err   = own0 & (wb_err | timeout);
  assign p0_stall = ~own0 | wb_stall | ~room;
  assign p0_idata = own0 ? wb_idata : 32'd0;

  assign p1_ack   = own1 & wb_ack;
  assign p1_err   = own1 & (wb_err | timeout);
  assign p1_stall = ~own1 | wb_stall | ~room;
  assign p1_idata = own1 ? wb_idata : 32'd0;

  // ---------------------------------------------------------------------------
  // Tenure state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;   // makes port 0 win the first tie
      outstanding <= 4'd0;
      wdog        <= 16'd0;
      abort_owner <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          outstanding <= 4'd0;
          wdog        <= 16'd0;
          // On a tie the port that did not hold the bus last wins.
          if (p0_cyc && (!p1_cyc || last_grant)) begin
            state      <= OWN0;
            last_grant <= 1'b0;
          end else if (p1_cyc) begin
            state      <= OWN1;
            last_grant <= 1'b1;
          end
        end

        OWN0, OWN1: begin
          if (!own_cyc) begin
            // Owner let go; responses still in flight are dropped.
            state       <= IDLE;
            outstanding <= 4'd0;
            wdog        <= 16'd0;
          end else if (timeout) begin
            state       <= ABORT;
            abort_owner <= own1;
            outstanding <= 4'd0;
            wdog        <= 16'd0;
          end else begin
            outstanding <= out_next;
            wdog        <= counting ? (wdog + 16'd1) : 16'd0;
          end
        end

        ABORT: begin
          // Hold the bus released until the aborted owner drops cyc, so it
          // cannot confuse a fresh tenure with the one that was killed.
          outstanding <= 4'd0;
          wdog        <= 16'd0;
          if (!abort_cyc) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Purpose: self-checking bench for wb_bus_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Latency: inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
// Backpressure: random slave stall/ack/err and random requester cyc/stb exercise stall and depth limits.

module tb_wb_bus_arbiter;

  localparam int MAXO = 4;
  localparam int TOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [1:0]  p_cyc;
  logic [1:0]  p_stb;
  logic [1:0]  p_we;
  logic [29:0] p_addr [2];
  logic [3:0]  p_sel  [2];
  logic [31:0] p_wdat [2];

  logic        p0_ack, p0_err, p0_stall;
  logic        p1_ack, p1_err, p1_stall;
  logic [31:0] p0_idata, p1_idata;

  logic        wb_cyc, wb_stb, wb_we;
  logic [29:0] wb_addr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_odata;
  logic        wb_ack, wb_stall, wb_err;
  logic [31:0] wb_idata;

  int n_tests = 0;
  int n_fail  = 0;

  wb_bus_arbiter #(
    .MAX_OUTSTANDING (MAXO),
    .TIMEOUT_CYCLES  (TOUT)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .p0_cyc    (p_cyc[0]),
    .p0_stb    (p_stb[0]),
    .p0_we     (p_we[0]),
    .p0_addr   (p_addr[0]),
    .p0_sel    (p_sel[0]),
    .p0_odata  (p_wdat[0]),
    .p0_ack    (p0_ack),
    .p0_err    (p0_err),
    .p0_stall  (p0_stall),
    .p0_idata  (p0_idata),
    .p1_cyc    (p_cyc[1]),
    .p1_stb    (p_stb[1]),
    .p1_we     (p_we[1]),
    .p1_addr   (p_addr[1]),
    .p1_sel    (p_sel[1]),
    .p1_odata  (p_wdat[1]),
    .p1_ack    (p1_ack),
    .p1_err    (p1_err),
    .p1_stall  (p1_stall),
    .p1_idata  (p1_idata),
    .wb_cyc    (wb_cyc),
    .wb_stb    (wb_stb),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_sel    (wb_sel),
    .wb_odata  (wb_odata),
    .wb_ack    (wb_ack),
    .wb_stall  (wb_stall),
    .wb_err    (wb_err),
    .wb_idata  (wb_idata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: who holds the bus, how many requests are in flight,
  // how long the owner has been waiting. Checked every falling edge.
  // ---------------------------------------------------------------------------
  int m_owner    = -1;   // -1: bus free, else port number holding the tenure
  bit m_aborted  = 1'b0; // tenure killed, waiting for owner to let go
  int m_last     = 1;
  int m_inflight = 0;
  int m_waited   = 0;

  always @(negedge clk) begin : model
    bit granted, ocyc, e_stb, resp, hung, acc, mine0, mine1;
    int own, pick;
    if (!rst_n) begin
      m_owner    = -1;
      m_aborted  = 1'b0;
      m_last     = 1;
      m_inflight = 0;
      m_waited   = 0;
    end
    granted = (m_owner >= 0) && !m_aborted;
    own     = (granted && m_owner == 1) ? 1 : 0;
    ocyc    = granted && p_cyc[own];
    e_stb   = ocyc && p_stb[own] && (m_inflight < MAXO);
    resp    = wb_ack || wb_err;
    hung    = granted && (m_inflight > 0) && !resp && (m_waited == TOUT - 1);
    mine0   = granted && (m_owner == 0);
    mine1   = granted && (m_owner == 1);

    check("m_wb_ctl", 64'({wb_cyc, wb_stb, wb_we, wb_sel}),
          64'({ocyc, e_stb, p_we[own], p_sel[own]}));
    check("m_wb_addr", 64'(wb_addr), 64'(p_addr[own]));
    check("m_wb_odata", 64'(wb_odata), 64'(p_wdat[own]));
    check("m_p0_rsp", 64'({p0_ack, p0_err, p0_stall}),
          64'({mine0 && wb_ack, mine0 && (wb_err || hung),
               !mine0 || wb_stall || (m_inflight >= MAXO)}));
    check("m_p1_rsp", 64'({p1_ack, p1_err, p1_stall}),
          64'({mine1 && wb_ack, mine1 && (wb_err || hung),
               !mine1 || wb_stall || (m_inflight >= MAXO)}));
    check("m_p0_idata", 64'(p0_idata), mine0 ? 64'(wb_idata) : 64'd0);
    check("m_p1_idata", 64'(p1_idata), mine1 ? 64'(wb_idata) : 64'd0);

    if (rst_n) begin
      if (m_owner < 0) begin
        if (p_cyc == 2'b11)   pick = 1 - m_last;
        else if (p_cyc[0])    pick = 0;
        else if (p_cyc[1])    pick = 1;
        else                  pick = -1;
        if (pick >= 0) begin
          m_owner = pick;
          m_last  = pick;
        end
        m_inflight = 0;
        m_waited   = 0;
      end else if (m_aborted) begin
        if (!p_cyc[m_owner]) begin
          m_owner   = -1;
          m_aborted = 1'b0;
        end
      end else if (!p_cyc[m_owner]) begin
        m_owner    = -1;
        m_inflight = 0;
        m_waited   = 0;
      end else if (hung) begin
        m_aborted  = 1'b1;
        m_inflight = 0;
        m_waited   = 0;
      end else begin
        acc      = e_stb && !wb_stall;
        m_waited = (m_inflight > 0 && !resp) ? m_waited + 1 : 0;
        if (acc && !resp)                          m_inflight++;
        else if (!acc && resp && m_inflight > 0)   m_inflight--;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int acc;
    int win;
    bit quiet;

    p_cyc = 2'b00; p_stb = 2'b00; p_we = 2'b00;
    for (int k = 0; k < 2; k++) begin
      p_addr[k] = '0; p_sel[k] = '0; p_wdat[k] = '0;
    end
    wb_ack = 1'b0; wb_stall = 1'b0; wb_err = 1'b0; wb_idata = '0;
    quiet = 1'b0;

    // Reset state
    tick; tick;
    @(negedge clk);
    check("rst_wb", 64'({wb_cyc, wb_stb}), 64'd0);
    check("rst_stall", 64'({p0_stall, p1_stall}), 64'b11);
    check("rst_rsp", 64'({p0_ack, p0_err, p1_ack, p1_err}), 64'd0);
    check("rst_idata", 64'({p0_idata, p1_idata}), 64'd0);
    tick;
    rst_n = 1'b1;
    tick;

    // Single port-0 read
    p_cyc[0] = 1'b1; p_stb[0] = 1'b1; p_addr[0] = 30'h123;
    @(negedge clk);
    check("rd_idle_cyc", 64'(wb_cyc), 64'd0);
    tick;
    @(negedge clk);
    check("rd_grant", 64'({wb_cyc, wb_stb, p0_stall}), 64'b110);
    check("rd_addr", 64'(wb_addr), 64'h123);
    tick;
    p_stb[0] = 1'b0; wb_ack = 1'b1; wb_idata = 32'hDEADBEEF;
    @(negedge clk);
    check("rd_ack", 64'({p0_ack, p1_ack}), 64'b10);
    check("rd_idata", 64'(p0_idata), 64'hDEADBEEF);
    tick;
    wb_ack = 1'b0; wb_idata = '0; p_cyc[0] = 1'b0;
    tick; tick;

    // Tie after reset: port 0 first, port 1 after one idle cycle
    do_reset;
    p_cyc = 2'b11;
    tick;
    @(negedge clk);
    check("tie0_stall", 64'({p0_stall, p1_stall}), 64'b01);
    tick;
    p_cyc[0] = 1'b0;
    @(negedge clk);
    check("tie0_rel", 64'(wb_cyc), 64'd0);
    tick;
    @(negedge clk);
    check("tie0_idle", 64'({wb_cyc, p1_stall}), 64'b01);
    tick;
    @(negedge clk);
    check("tie0_own1", 64'({wb_cyc, p1_stall}), 64'b10);
    p_cyc[1] = 1'b0;
    tick; tick;

    // Four ties where both drop together: winner alternates
    for (int t = 0; t < 4; t++) begin
      win = t % 2;
      p_cyc = 2'b11;
      tick;
      @(negedge clk);
      check("tie_alt", 64'({p0_stall, p1_stall}), (win == 0) ? 64'b01 : 64'b10);
      tick;
      p_cyc = 2'b00;
      tick; tick;
    end

    // Depth limit: 4 accepted with no acks, one ack frees exactly one slot
    p_cyc[0] = 1'b1; p_stb[0] = 1'b1;
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (wb_stb && !wb_stall) acc++;
      tick;
    end
    check("burst_acc", 64'(acc), 64'd4);
    @(negedge clk);
    check("burst_full", 64'({p0_stall, wb_stb}), 64'b10);
    tick;
    wb_ack = 1'b1;
    acc = 0;
    @(negedge clk);
    if (wb_stb && !wb_stall) acc++;
    tick;
    wb_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wb_stb && !wb_stall) acc++;
      tick;
    end
    check("burst_one_more", 64'(acc), 64'd1);

    // Ack and accepted strobe together at outstanding=2
    p_stb[0] = 1'b0; wb_ack = 1'b1;
    tick; tick;
    p_stb[0] = 1'b1;
    @(negedge clk);
    check("both_stb", 64'({wb_stb, wb_ack}), 64'b11);
    tick;
    wb_ack = 1'b0;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wb_stb && !wb_stall) acc++;
      tick;
    end
    check("both_keep2", 64'(acc), 64'd2);
    p_stb[0] = 1'b0; p_cyc[0] = 1'b0;
    tick; tick; tick;

    // Watchdog timeout, abort, port 1 waits for IDLE
    p_cyc[0] = 1'b1; p_stb[0] = 1'b1;
    tick;
    tick;
    p_stb[0] = 1'b0;
    for (int w = 1; w <= 8; w++) begin
      @(negedge clk);
      check("tmo_err", 64'({p0_err, wb_cyc}), 64'({w == 8, 1'b1}));
      tick;
    end
    @(negedge clk);
    check("abort_cyc", 64'({wb_cyc, p0_stall, p0_err}), 64'b010);
    p_cyc[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      @(negedge clk);
      check("abort_hold", 64'({wb_cyc, p1_stall, p0_stall}), 64'b011);
    end
    tick;
    p_cyc[0] = 1'b0;
    @(negedge clk);
    check("abort_exit", 64'({wb_cyc, p1_stall}), 64'b01);
    tick;
    @(negedge clk);
    check("abort_idle", 64'({wb_cyc, p1_stall}), 64'b01);
    tick;
    @(negedge clk);
    check("abort_own1", 64'({wb_cyc, p1_stall}), 64'b10);
    p_cyc[1] = 1'b0;
    tick; tick;

    // Reset in the middle of a burst with three in flight
    p_cyc[0] = 1'b1; p_stb[0] = 1'b1;
    tick; tick; tick; tick;
    check("pre_rst_cyc", 64'(wb_cyc), 64'd1);
    p_stb[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_cyc", 64'({wb_cyc, p0_err, p0_ack}), 64'd0);
    p_cyc[0] = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    p_cyc = 2'b11; p_stb = 2'b01;
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (wb_stb && !wb_stall) acc++;
      tick;
    end
    check("post_rst_acc", 64'(acc), 64'd4);
    check("post_rst_p1", 64'(p1_stall), 64'd1);
    p_cyc = 2'b00; p_stb = 2'b00;
    tick; tick;

    // Randomized traffic; the model checks every cycle
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) quiet = ($urandom % 2 == 0);
      for (int k = 0; k < 2; k++) begin
        if (!p_cyc[k])                 p_cyc[k] = ($urandom % 4 == 0);
        else if ($urandom % 12 == 0)   p_cyc[k] = 1'b0;
        p_stb[k]  = p_cyc[k] & ($urandom % 3 != 0);
        p_we[k]   = 1'($urandom);
        p_addr[k] = 30'($urandom);
        p_sel[k]  = 4'($urandom);
        p_wdat[k] = $urandom;
      end
      wb_ack   = quiet ? ($urandom % 32 == 0) : ($urandom % 2 == 0);
      wb_err   = ($urandom % 40 == 0);
      wb_stall = ($urandom % 4 == 0);
      wb_idata = $urandom;
      rst_n    = ($urandom % 600 != 0);
      tick;
    end

    rst_n = 1'b1;
    p_cyc = 2'b00; p_stb = 2'b00;
    wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0;
    tick; tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
